// File: rtl/alu_pkg.sv
// Shared constants and op decode for the ALU result stage.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] OP_CLEAR = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_ACC   = 4'b0010;
    localparam logic [3:0] OP_READ  = 4'b0001;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [2:0] {
        OPK_CLEAR,
        OPK_LOAD,
        OPK_ACC,
        OPK_READ,
        OPK_ILLEGAL
    } op_kind_e;

    // Anything other than exactly one recognised bit is illegal.
    function automatic op_kind_e decode_op(input logic [3:0] op);
        op_kind_e k;
        case (op)
            OP_CLEAR: k = OPK_CLEAR;
            OP_LOAD:  k = OPK_LOAD;
            OP_ACC:   k = OPK_ACC;
            OP_READ:  k = OPK_READ;
            default:  k = OPK_ILLEGAL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small power-of-two FIFO with asynchronously cleared storage; head is the read slot.
module result_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_en, pop_en;

    assign push_en = push && (count_q != FULL);
    assign pop_en  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU output stage: applies a one-hot op to the accumulator and queues {acc, V, C, Z}.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N     = ALU_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] res_in,
    input  logic [3:0]   op_s,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] acc_val,
    output logic [N-1:0] out_data,
    output logic [2:0]   out_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sel_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [N-1:0]  acc_q, acc_d;
    logic          sel_err_q, sel_err_d;
    logic [CW-1:0] count;
    logic [N+2:0]  head;
    logic [N:0]    sum;
    logic [2:0]    flags;
    logic [N-1:0]  push_val;
    logic          push;
    logic          accept;
    op_kind_e      op_kind;

    assign in_ready = (count < FULL);
    assign accept   = in_valid && in_ready;
    assign op_kind  = decode_op(op_s);
    assign sum      = {1'b0, acc_q} + {1'b0, res_in};

    always_comb begin
        acc_d     = acc_q;
        push      = 1'b0;
        push_val  = acc_q;
        flags     = '0;
        sel_err_d = 1'b0;
        if (accept) begin
            case (op_kind)
                OPK_CLEAR: begin
                    acc_d         = '0;
                    push          = 1'b1;
                    push_val      = '0;
                    flags[FLAG_Z] = 1'b1;
                end
                OPK_LOAD: begin
                    acc_d         = res_in;
                    push          = 1'b1;
                    push_val      = res_in;
                    flags[FLAG_Z] = (res_in == '0);
                end
                OPK_ACC: begin
                    acc_d         = sum[N-1:0];
                    push          = 1'b1;
                    push_val      = sum[N-1:0];
                    flags[FLAG_Z] = (sum[N-1:0] == '0);
                    flags[FLAG_C] = sum[N];
                    // Signed overflow: like-signed operands produce an opposite-signed result.
                    flags[FLAG_V] = (acc_q[N-1] == res_in[N-1]) && (sum[N-1] != acc_q[N-1]);
                end
                OPK_READ: begin
                    push          = 1'b1;
                    push_val      = acc_q;
                    flags[FLAG_Z] = (acc_q == '0);
                end
                default: sel_err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sel_err_q <= sel_err_d;
        end
    end

    result_fifo #(
        .W     (N + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_val, flags}),
        .pop       (out_valid && out_ready),
        .head_data (head),
        .count     (count)
    );

    assign acc_val   = acc_q;
    assign sel_err   = sel_err_q;
    assign out_valid = (count != '0);
    assign out_data  = head[N+2:3];
    assign out_flags = head[2:0];

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected FIFO entries queued at accept, checked at pop.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] res_in = '0;
    logic [3:0]  op_s = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] acc_val;
    logic [15:0] out_data;
    logic [2:0]  out_flags;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sel_err;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [18:0] sb[$];
    logic [15:0] m_acc = '0;

    alu_result_stage #(.N(16), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_in    (res_in),
        .op_s      (op_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_val   (acc_val),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of one accepted op; returns 1 if it should push.
    function automatic bit model(input logic [3:0] op, input logic [15:0] r, output logic [18:0] ent);
        logic [16:0] s;
        ent = '0;
        case (op)
            OP_CLEAR: begin m_acc = 16'h0; ent = {16'h0, 3'b001}; return 1; end
            OP_LOAD:  begin m_acc = r; ent = {r, 2'b00, r == 16'h0}; return 1; end
            OP_ACC: begin
                s = {1'b0, m_acc} + {1'b0, r};
                ent = {s[15:0], (m_acc[15] == r[15]) && (s[15] != m_acc[15]), s[16], s[15:0] == 16'h0};
                m_acc = s[15:0];
                return 1;
            end
            OP_READ:  begin ent = {m_acc, 2'b00, m_acc == 16'h0}; return 1; end
            default:  return 0;
        endcase
    endfunction

    // Drive one transaction starting just after a rising edge; returns just after its accept edge.
    task automatic send(input logic [3:0] op, input logic [15:0] r);
        logic [18:0] ent;
        bit legal;
        bit done = 0;
        in_valid = 1'b1;
        op_s     = op;
        res_in   = r;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                legal = model(op, r, ent);
                if (legal) sb.push_back(ent);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            chk("accept_timeout", 0, 1);
        end else begin
            chk("acc_val", acc_val, m_acc);
            chk("sel_err", sel_err, !legal);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_pop", {out_data, out_flags}, 0);
            else chk("head", {out_data, out_flags}, sb.pop_front());
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle(2);
        chk("rst_acc", acc_val, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_head", {out_data, out_flags}, 0);
        rst = 1'b0;
        idle(1);

        out_ready = 1'b1;
        send(OP_LOAD, 16'h00FF);
        chk("load_valid", out_valid, 1);
        chk("load_head", {out_data, out_flags}, {16'h00FF, 3'b000});
        idle(2);

        // Carry and signed overflow cases, back to back.
        send(OP_LOAD, 16'hFFFF);
        send(OP_ACC, 16'h0001);
        send(OP_LOAD, 16'h7FFF);
        send(OP_ACC, 16'h0001);
        send(OP_ACC, 16'h8000);
        send(OP_READ, 16'h5555);
        send(OP_CLEAR, 16'h1234);
        send(OP_READ, 16'h0000);
        send(OP_LOAD, 16'h0000);
        idle(4);
        chk("drained", out_valid, 0);

        // Illegal op: pulse for one cycle, no state change, no push.
        send(OP_LOAD, 16'hABCD);
        idle(3);
        send(4'b0110, 16'h1111);
        chk("illegal_valid", out_valid, 0);
        idle(1);
        chk("sel_err_one_cycle", sel_err, 0);
        chk("illegal_acc", acc_val, 16'hABCD);
        send(4'b0000, 16'h2222);
        idle(1);

        // Backpressure: two fill the FIFO, third is held.
        out_ready = 1'b0;
        send(OP_LOAD, 16'h0001);
        send(OP_LOAD, 16'h0002);
        chk("full_ready", in_ready, 0);
        in_valid = 1'b1;
        op_s = OP_LOAD;
        res_in = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_ready", in_ready, 0);
            chk("held_acc", acc_val, 16'h0002);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(OP_LOAD, 16'h0003);
        idle(4);

        // Steady push/pop at count 1 exercises pointer wrap.
        send(OP_LOAD, 16'h0010);
        for (int i = 0; i < 5; i++) begin
            send(OP_ACC, 16'h0010);
            chk("pp_valid", out_valid, 1);
            chk("pp_ready", in_ready, 1);
            chk("pp_count", dut.count, 1);
        end
        idle(4);
        chk("sb_drained", sb.size(), 0);

        // Asynchronous reset with two queued entries.
        out_ready = 1'b0;
        send(OP_LOAD, 16'h1111);
        send(OP_LOAD, 16'h1234);
        chk("pre_rst_acc", acc_val, 16'h1234);
        #2 rst = 1'b1;
        #1;
        chk("arst_acc", acc_val, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_head", {out_data, out_flags}, 0);
        chk("arst_sel_err", sel_err, 0);
        sb.delete();
        m_acc = '0;
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        send(OP_READ, 16'h0000);
        idle(3);
        chk("final_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
